// File: rtl/fifo_packer.sv
// Packs RATIO consecutive upstream FIFO words into one wide beat with a valid/ready handshake.
// Define FIFO_PACKER_PARITY_EN to add a per-lane even-parity output (out_parity).
module fifo_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             fifo_dout,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic                         flush,
  output logic [WIDTH*RATIO-1:0]       out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
`ifdef FIFO_PACKER_PARITY_EN
  ,
  output logic [RATIO-1:0]             out_parity
`endif
);

  localparam int IDX_W = $clog2(RATIO);
  localparam int CNT_W = $clog2(RATIO+1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO-1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lane_q [RATIO];
  logic [WIDTH-1:0] lane_d [RATIO];
  logic             pop;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Pops are gated by reset so nothing is drained from the FIFO while the packer is held.
  always_comb begin
    if (state_q == FILL) pop = ~fifo_empty & ~flush;
    else                 pop = out_ready & ~fifo_empty;
    fifo_rd_en = rst & pop;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    if (state_q == FILL) begin
      if (fifo_rd_en) begin
        lane_d[idx_q] = fifo_dout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cnt_d   = CNT_W'(RATIO);
          state_d = HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (flush && (idx_q != '0)) begin
        for (int k = 0; k < RATIO; k++) begin
          if (k >= int'(idx_q)) lane_d[k] = '0;
        end
        cnt_d   = CNT_W'(idx_q);
        idx_d   = '0;
        state_d = HOLD;
      end
    end else if (out_ready) begin
      // Handshake: start a fresh beat, absorbing a same-cycle pop into lane 0.
      for (int k = 0; k < RATIO; k++) lane_d[k] = '0;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = FILL;
      if (fifo_rd_en) begin
        lane_d[0] = fifo_dout;
        idx_d     = IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < RATIO; k++) lane_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < RATIO; k++) lane_q[k] <= lane_d[k];
    end
  end

`ifdef FIFO_PACKER_PARITY_EN
  logic [RATIO-1:0] par_q;

  // Parity tracks lane_d so it is registered on exactly the same edge as the lane itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= '0;
    end else begin
      for (int k = 0; k < RATIO; k++) par_q[k] <= even_parity(lane_d[k]);
    end
  end

  assign out_parity = par_q;
`endif

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign out_data[g*WIDTH +: WIDTH] = lane_q[g];
  end

  assign out_count = cnt_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (idx_q != '0) | out_valid;

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer (WIDTH=8, RATIO=4) with a behavioural upstream FIFO.
// Build with FIFO_PACKER_PARITY_EN defined to also exercise out_parity.
module tb_fifo_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
`ifdef FIFO_PACKER_PARITY_EN
  logic [3:0]  out_parity;
`endif

  fifo_packer #(.WIDTH(8), .RATIO(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef FIFO_PACKER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: tasks write, the clocked process below pops.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr];
  always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
    int          t;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs [64];
  int    obs_wr = 0;
  int    obs_rd = 0;
  int    empty_pop_viol = 0;

  // Monitor: records every accepted beat and any pop against an empty FIFO.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      obs[obs_wr % 64] = '{data: out_data, cnt: out_count, t: cyc};
      obs_wr = obs_wr + 1;
    end
    if (fifo_rd_en && fifo_empty) empty_pop_viol = empty_pop_viol + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_word(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [2:0] c);
    exp_q.push_back('{data: d, cnt: c, t: 0});
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && (obs_wr - obs_rd) < n; i++) tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    push_word(8'h5E);
    tick(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", out_data); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    rst = 1'b1;
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy got %b want 1", busy); end
    expect_beat(32'h0000005E, 3'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_beats(1, 10);
    checks++;
    if (obs_wr - obs_rd < 1) begin
      errors++; $display("FAIL flush1_timeout got %0d beats want 1", obs_wr - obs_rd);
    end else begin
      beat_t o, e;
      o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
      if (o.data !== e.data || o.cnt !== e.cnt) begin
        errors++; $display("FAIL flush1_beat got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt);
      end
    end
    exp_q.delete();
    tick(2);
  endtask

  task automatic test_basic;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    expect_beat(32'h44332211, 3'd4);
    wait_beats(1, 20);
    checks++;
    if (obs_wr - obs_rd < 1) begin
      errors++; $display("FAIL basic_timeout got %0d beats want 1", obs_wr - obs_rd);
    end else begin
      beat_t o, e;
      o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
      if (o.data !== e.data || o.cnt !== e.cnt) begin
        errors++; $display("FAIL basic_beat got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt);
      end
    end
    exp_q.delete();
    tick(2);
    checks++; if (busy !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL basic_idle got busy=%b empty=%b want busy=0 empty=1", busy, fifo_empty);
    end
  endtask

  task automatic test_flush;
    push_word(8'hAA); push_word(8'hBB);
    expect_beat(32'h0000BBAA, 3'd2);
    tick(4);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_pre got busy=%b valid=%b want 1/0", busy, out_valid);
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_beats(1, 10);
    checks++;
    if (obs_wr - obs_rd < 1) begin
      errors++; $display("FAIL flush_timeout got %0d beats want 1", obs_wr - obs_rd);
    end else begin
      beat_t o, e;
      o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
      if (o.data !== e.data || o.cnt !== e.cnt) begin
        errors++; $display("FAIL flush_beat got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt);
      end
    end
    exp_q.delete();
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(5);
    checks++; if (obs_wr != obs_rd || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle got beats=%0d valid=%b want 0/0", obs_wr - obs_rd, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int t0;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(8'hA0 + 8'(i));
    expect_beat(32'hA4A3A2A1, 3'd4);
    expect_beat(32'hA8A7A6A5, 3'd4);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (out_data !== 32'hA4A3A2A1 || out_count !== 3'd4 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_stable got %h/%0d/%b want a4a3a2a1/4/1", out_data, out_count, out_valid);
      end
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en got %b want 0", fifo_rd_en); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL bp_pop_on_hs got %b want 1", fifo_rd_en); end
    wait_beats(2, 20);
    checks++;
    if (obs_wr - obs_rd < 2) begin
      errors++; $display("FAIL bp_timeout got %0d beats want 2", obs_wr - obs_rd);
    end else begin
      t0 = obs[obs_rd % 64].t;
      for (int i = 0; i < 2; i++) begin
        beat_t o, e;
        o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
        checks++; if (o.data !== e.data || o.cnt !== e.cnt) begin
          errors++; $display("FAIL bp_beat%0d got %h/%0d want %h/%0d", i, o.data, o.cnt, e.data, e.cnt);
        end
        if (i == 1) begin
          checks++; if (o.t - t0 != 4) begin errors++; $display("FAIL bp_spacing got %0d want 4", o.t - t0); end
        end
      end
    end
    exp_q.delete();
    tick(2);
  endtask

  task automatic test_stream;
    int tp;
    out_ready = 1'b1;
    for (int i = 1; i <= 12; i++) push_word(8'(i));
    expect_beat(32'h04030201, 3'd4);
    expect_beat(32'h08070605, 3'd4);
    expect_beat(32'h0C0B0A09, 3'd4);
    wait_beats(3, 40);
    checks++;
    if (obs_wr - obs_rd < 3) begin
      errors++; $display("FAIL stream_timeout got %0d beats want 3", obs_wr - obs_rd);
    end else begin
      tp = obs[obs_rd % 64].t;
      for (int i = 0; i < 3; i++) begin
        beat_t o, e;
        o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
        checks++; if (o.data !== e.data || o.cnt !== e.cnt) begin
          errors++; $display("FAIL stream_beat%0d got %h/%0d want %h/%0d", i, o.data, o.cnt, e.data, e.cnt);
        end
        if (i > 0) begin
          checks++; if (o.t - tp != 4) begin errors++; $display("FAIL stream_spacing%0d got %0d want 4", i, o.t - tp); end
        end
        tp = o.t;
      end
    end
    exp_q.delete();
    tick(2);
  endtask

  task automatic test_reset_mid;
    push_word(8'hC1); push_word(8'hC2);
    tick(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got valid=%b data=%h busy=%b want 0/00000000/0", out_valid, out_data, busy);
    end
    tick(2);
    rst = 1'b1;
    tick(3);
    checks++; if (obs_wr != obs_rd || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_beat got beats=%0d busy=%b want 0/0", obs_wr - obs_rd, busy);
    end
    push_word(8'hD1); push_word(8'hD2); push_word(8'hD3); push_word(8'hD4);
    expect_beat(32'hD4D3D2D1, 3'd4);
    wait_beats(1, 20);
    checks++;
    if (obs_wr - obs_rd < 1) begin
      errors++; $display("FAIL mid_timeout got %0d beats want 1", obs_wr - obs_rd);
    end else begin
      beat_t o, e;
      o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
      if (o.data !== e.data || o.cnt !== e.cnt) begin
        errors++; $display("FAIL mid_beat got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt);
      end
    end
    exp_q.delete();
    tick(2);
  endtask

`ifdef FIFO_PACKER_PARITY_EN
  task automatic test_parity;
    out_ready = 1'b0;
    push_word(8'h01); push_word(8'h03); push_word(8'h07); push_word(8'h00);
    expect_beat(32'h00070301, 3'd4);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick(1);
    checks++; if (out_parity !== 4'b0101) begin errors++; $display("FAIL parity got %b want 0101", out_parity); end
    out_ready = 1'b1;
    wait_beats(1, 10);
    checks++;
    if (obs_wr - obs_rd < 1) begin
      errors++; $display("FAIL parity_timeout got %0d beats want 1", obs_wr - obs_rd);
    end else begin
      beat_t o, e;
      o = obs[obs_rd % 64]; obs_rd++; e = exp_q.pop_front();
      if (o.data !== e.data || o.cnt !== e.cnt) begin
        errors++; $display("FAIL parity_beat got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt);
      end
    end
    exp_q.delete();
    tick(2);
    checks++; if (out_parity !== 4'b0000) begin errors++; $display("FAIL parity_clear got %b want 0000", out_parity); end
  endtask
`endif

  task automatic test_no_empty_pop;
    checks++; if (empty_pop_viol != 0) begin
      errors++; $display("FAIL empty_pop got %0d want 0", empty_pop_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_stream();
    test_reset_mid();
`ifdef FIFO_PACKER_PARITY_EN
    test_parity();
`endif
    test_no_empty_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one upstream FIFO word.
REQ-002 Parameter RATIO, default 4: words packed per output beat; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fifo_dout  input  WIDTH  upstream FIFO read data; valid whenever fifo_empty=0.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_rd_en  output  1  pop request to upstream FIFO; combinational.
REQ-008 flush  input  1  request to emit a partially filled beat.
REQ-009 out_data  output  WIDTH*RATIO  packed beat; word k occupies bits [k*WIDTH +: WIDTH], word 0 first popped.
REQ-010 out_count  output  $clog2(RATIO+1)  number of valid words in out_data.
REQ-011 out_valid  output  1  beat available.
REQ-012 out_ready  input  1  downstream accepts beat when high with out_valid.
REQ-013 busy  output  1  high when idx!=0 or out_valid=1.

Function
REQ-014 Two states SHALL exist: FILL (collecting words, out_valid=0) and HOLD (beat presented, out_valid=1).
REQ-015 Internal lane index idx (0..RATIO-1) SHALL select the out_data lane written by the next pop.
REQ-016 In FILL, fifo_rd_en SHALL equal ~fifo_empty & ~flush.
REQ-017 In HOLD, fifo_rd_en SHALL equal out_ready & ~fifo_empty.
REQ-018 Each pop SHALL register fifo_dout into lane idx at the same clock edge; one pop per cycle maximum.
REQ-019 A pop in FILL with idx<RATIO-1 SHALL increment idx and stay in FILL.
REQ-020 A pop in FILL with idx=RATIO-1 SHALL set idx=0, out_count=RATIO, enter HOLD (out_valid high next cycle).
REQ-021 flush=1 in FILL with idx>0 SHALL enter HOLD with out_count=idx, lanes >= idx driven to zero, idx=0; no pop that cycle.
REQ-022 flush=1 in FILL with idx=0, and flush in HOLD, SHALL be ignored.
REQ-023 In HOLD, out_data, out_count, out_valid SHALL stay stable until out_valid&out_ready.
REQ-024 Handshake in HOLD without pop SHALL return to FILL with idx=0 and all lanes cleared.
REQ-025 Handshake in HOLD with a simultaneous pop SHALL return to FILL, write the popped word into lane 0, clear lanes 1..RATIO-1, set idx=1 (no bubble).
REQ-026 Sustained throughput SHALL be one beat per RATIO cycles when FIFO non-empty and out_ready held high.
REQ-027 fifo_rd_en SHALL never assert while fifo_empty=1.

Reset
REQ-028 rst low SHALL asynchronously force state=FILL, idx=0, out_data=0, out_count=0, out_valid=0; fifo_rd_en and busy then low.
REQ-029 Reset mid-beat SHALL discard partial and held words; no beat emitted for them after release.

Configuration
REQ-030 Macro FIFO_PACKER_PARITY_EN defined: output out_parity [RATIO] SHALL exist, bit k = even parity (XOR) of lane k, registered with the lane, zero on reset and for unused lanes.
REQ-031 Macro undefined: out_parity port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 WIDTH=8, RATIO=4, FIFO holds 11,22,33,44, out_ready=1 -> 4 pops, then out_valid=1, out_data=0x44332211, out_count=4.
REQ-033 FIFO holds AA,BB then empty, flush pulse -> out_data=0x0000BBAA, out_count=2; flush with idx=0 -> no beat.
REQ-034 out_ready=0 for 5 cycles during HOLD with FIFO non-empty -> out_data stable, fifo_rd_en=0; ready rises -> handshake and pop same cycle, idx=1.
REQ-035 Continuous stream 01..0C, out_ready=1 -> beats 0x04030201, 0x08070605, 0x0C0B0A09 at 4-cycle spacing.
REQ-036 rst asserted with idx=2 -> out_valid=0, out_data=0, busy=0 immediately; after release 4 new words yield one beat containing only them.
REQ-037 With FIFO_PACKER_PARITY_EN, lane values 0x01,0x03,0x07,0x00 -> out_parity=4'b0101.
